// File: rtl/sm4_req_scheduler.sv
// Request-level scheduler sharing one SM4 round datapath between two requesters.
// Round-robin grant in IDLE, ROUNDS-cycle run, then a held valid/ready response.
module sm4_req_scheduler #(
  parameter int unsigned ROUNDS = 32,
  parameter int unsigned CW     = 6
) (
  input  logic          CLK,
  input  logic          REST,
  input  logic          REQ0_VALID,
  output logic          REQ0_READY,
  input  logic [127:0]  REQ0_KEY,
  input  logic [127:0]  REQ0_MSG,
  input  logic          REQ1_VALID,
  output logic          REQ1_READY,
  input  logic [127:0]  REQ1_KEY,
  input  logic [127:0]  REQ1_MSG,
  output logic [127:0]  ENG_KEY,
  output logic [127:0]  ENG_MSG,
  output logic [CW-1:0] ENG_ROUND,
  output logic          ENG_FIRST,
  input  logic [127:0]  ENG_RESULT,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic          RSP_ID,
  output logic [127:0]  RSP_DATA,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_gnt_q, last_gnt_d;
  logic           id_q, id_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   msg_q, msg_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [127:0]   rsp_data_q, rsp_data_d;

  logic           gnt_valid;
  logic           gnt_id;
  logic           last_round;

  assign last_round = (cnt_q == LAST_ROUND);

  // Round-robin: on contention the port that did not win last time goes next.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (REQ0_VALID && REQ1_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_gnt_q;
      end else if (REQ0_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (REQ1_VALID) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gnt_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_round) state_d = ST_RESP;
      ST_RESP: if (RSP_READY)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    id_d        = id_q;
    key_d       = key_q;
    msg_d       = msg_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          key_d      = gnt_id ? REQ1_KEY : REQ0_KEY;
          msg_d      = gnt_id ? REQ1_MSG : REQ0_MSG;
          id_d       = gnt_id;
          last_gnt_d = gnt_id;
          cnt_d      = '0;
        end
      end
      ST_RUN: begin
        if (last_round) begin
          cnt_d       = '0;
          rsp_data_d  = ENG_RESULT;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge REST) begin
    if (!REST) begin
      cnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      id_q        <= 1'b0;
      key_q       <= '0;
      msg_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      id_q        <= id_d;
      key_q       <= key_d;
      msg_q       <= msg_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    REQ0_READY = gnt_valid && !gnt_id;
    REQ1_READY = gnt_valid &&  gnt_id;
    ENG_KEY    = key_q;
    ENG_MSG    = msg_q;
    ENG_ROUND  = (state_q == ST_RUN) ? cnt_q : '0;
    ENG_FIRST  = (state_q == ST_RUN) && (cnt_q == '0);
    RSP_VALID  = rsp_valid_q;
    RSP_ID     = rsp_id_q;
    RSP_DATA   = rsp_data_q;
    BUSY       = (state_q != ST_IDLE);
  end

endmodule
